// File: rtl/aes_inv_cipher_ctrl.sv
// Iterative AES inverse cipher: one shared round datapath, one round
// per clock, external round-key store addressed by rk_idx.
module aes_inv_cipher_ctrl #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ciphertext,
  output logic [3:0]   rk_idx,
  input  logic [127:0] round_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plaintext,
  output logic         busy
);

  if (NR != 10 && NR != 12 && NR != 14) begin : g_nr_check
    $error("aes_inv_cipher_ctrl: NR must be 10, 12 or 14");
  end

  localparam logic [3:0] NR4   = 4'(NR);
  localparam logic [3:0] NR_M1 = 4'(NR - 1);

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    FINAL,
    DONE
  } fsm_e;

  fsm_e         fsm;
  fsm_e         fsm_nxt;
  logic [3:0]   r;
  logic [3:0]   r_nxt;
  logic [127:0] st;
  logic [127:0] st_nxt;
  logic [127:0] sr;
  logic [127:0] sb;
  logic [127:0] ark;
  logic [127:0] mc;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] e;
    p = 8'h01;
    e = 8'hfe;
    for (int i = 7; i >= 0; i--) begin
      p = gf_mul(p, p);
      if (e[i]) p = gf_mul(p, a);
    end
    return p;
  endfunction

  // Inverse affine transform followed by field inversion.
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] y;
    y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gf_inv(y);
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int rr = 0; rr < 4; rr++) begin
      for (int c = 0; c < 4; c++) begin
        o[127-8*(rr+4*c) -: 8] = s[127-8*(rr+4*((c-rr+4)%4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
    end
    return o;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0;
    logic [7:0] a1;
    logic [7:0] a2;
    logic [7:0] a3;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    logic [7:0] b3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    b0 = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b)
       ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
    b1 = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e)
       ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
    b2 = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09)
       ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
    b3 = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d)
       ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    return {b0, b1, b2, b3};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
    end
    return o;
  endfunction

  assign sr  = inv_shift_rows(st);
  assign sb  = inv_sub_bytes(sr);
  assign ark = sb ^ round_key;
  assign mc  = inv_mix_columns(ark);

  // Sequencer: next state, round counter, key index and datapath select.
  always_comb begin
    fsm_nxt = fsm;
    r_nxt   = r;
    st_nxt  = st;
    rk_idx  = 4'd0;
    unique case (fsm)
      IDLE: begin
        rk_idx = NR4;
        if (in_valid) begin
          st_nxt  = ciphertext ^ round_key;
          r_nxt   = NR_M1;
          fsm_nxt = ROUND;
        end
      end
      ROUND: begin
        rk_idx = r;
        st_nxt = mc;
        if (r == 4'd1) fsm_nxt = FINAL;
        else r_nxt = r - 4'd1;
      end
      FINAL: begin
        rk_idx  = 4'd0;
        st_nxt  = ark;
        fsm_nxt = DONE;
      end
      DONE: begin
        if (out_ready) fsm_nxt = IDLE;
      end
    endcase
  end

  // State register with synchronous reset that drops any block in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm <= IDLE;
      r   <= NR_M1;
      st  <= '0;
    end else begin
      fsm <= fsm_nxt;
      r   <= r_nxt;
      st  <= st_nxt;
    end
  end

  assign in_ready  = rst_n & (fsm == IDLE);
  assign out_valid = rst_n & (fsm == DONE);
  assign busy      = rst_n & (fsm != IDLE);
  assign plaintext = st;

endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// Directed bench for aes_inv_cipher_ctrl: FIPS-197 C.1 and C.3 vectors,
// backpressure, back-to-back blocks and reset mid-operation.
module tb_aes_inv_cipher_ctrl;

  localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C3_CT = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         in_valid_a;
  logic         in_ready_a;
  logic [127:0] ct_a;
  logic [3:0]   rk_idx_a;
  logic [127:0] rk_a;
  logic         out_valid_a;
  logic         out_ready_a;
  logic [127:0] pt_a;
  logic         busy_a;

  logic         in_valid_b;
  logic         in_ready_b;
  logic [127:0] ct_b;
  logic [3:0]   rk_idx_b;
  logic [127:0] rk_b;
  logic         out_valid_b;
  logic         out_ready_b;
  logic [127:0] pt_b;
  logic         busy_b;

  logic [31:0]  w [0:59];
  logic [127:0] ks_a [0:15];
  logic [127:0] ks_b [0:15];

  int nchk = 0;
  int nfail = 0;

  assign rk_a = ks_a[rk_idx_a];
  assign rk_b = ks_b[rk_idx_b];

  aes_inv_cipher_ctrl #(.NR(10)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid_a),
    .in_ready  (in_ready_a),
    .ciphertext(ct_a),
    .rk_idx    (rk_idx_a),
    .round_key (rk_a),
    .out_valid (out_valid_a),
    .out_ready (out_ready_a),
    .plaintext (pt_a),
    .busy      (busy_a)
  );

  aes_inv_cipher_ctrl #(.NR(14)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid_b),
    .in_ready  (in_ready_b),
    .ciphertext(ct_b),
    .rk_idx    (rk_idx_b),
    .round_key (rk_b),
    .out_valid (out_valid_b),
    .out_ready (out_ready_b),
    .plaintext (pt_b),
    .busy      (busy_b)
  );

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Forward S-box from first principles: inverse then affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    for (int c = 1; c < 256; c++) begin
      if (gmul(x, 8'(c)) == 8'h01) inv = 8'(c);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
         ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] v);
    return {sbox(v[31:24]), sbox(v[23:16]), sbox(v[15:8]), sbox(v[7:0])};
  endfunction

  task automatic expand(input logic [255:0] key, input int nk, input int nr);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4 * (nr + 1); i++) begin
      if (i < nk) begin
        w[i] = key[255-32*i -: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = xt(rc);
        end else if (nk > 6 && i % nk == 4) begin
          t = sub_word(t);
        end
        w[i] = w[i-nk] ^ t;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs,
                      input logic [3:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    rst_n       = 1'b0;
    in_valid_a  = 1'b0;
    out_ready_a = 1'b0;
    ct_a        = '0;
    in_valid_b  = 1'b0;
    out_ready_b = 1'b0;
    ct_b        = '0;
    for (int k = 0; k < 16; k++) begin
      ks_a[k] = '0;
      ks_b[k] = '0;
    end

    expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
    for (int k = 0; k <= 10; k++) ks_a[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
    for (int k = 0; k <= 14; k++) ks_b[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};

    // Reset held low.
    repeat (2) @(negedge clk);
    #1;
    chkb("rst_out_valid", out_valid_a, 1'b0);
    chkb("rst_busy", busy_a, 1'b0);
    chkb("rst_in_ready", in_ready_a, 1'b0);

    // Reset released.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chkb("rel_in_ready", in_ready_a, 1'b1);
    chk4("rel_rk_idx_a", rk_idx_a, 4'd10);
    chk4("rel_rk_idx_b", rk_idx_b, 4'd14);
    chk("rel_pt", pt_a, 128'h0);
    chkb("rel_out_valid", out_valid_a, 1'b0);
    chkb("rel_busy", busy_a, 1'b0);

    // AES-128 C.1, input noise during rounds, then backpressure.
    ct_a       = C1_CT;
    in_valid_a = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      ct_a = rnd128();
      #1;
      chk4("c1_rk_idx", rk_idx_a, 4'(10 - k));
      chkb("c1_in_ready", in_ready_a, 1'b0);
      chkb("c1_out_valid", out_valid_a, 1'b0);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      ct_a = rnd128();
      #1;
      chkb("bp_out_valid", out_valid_a, 1'b1);
      chk("bp_pt", pt_a, PT);
      chkb("bp_in_ready", in_ready_a, 1'b0);
    end
    @(negedge clk);
    out_ready_a = 1'b1;
    in_valid_a  = 1'b0;
    #1;
    chkb("bp_release_valid", out_valid_a, 1'b1);
    @(negedge clk);
    out_ready_a = 1'b0;
    #1;
    chkb("bp_after_valid", out_valid_a, 1'b0);
    chkb("bp_after_ready", in_ready_a, 1'b1);
    chkb("bp_after_busy", busy_a, 1'b0);
    chk("bp_after_pt", pt_a, PT);

    // Back-to-back C.1 blocks.
    ct_a        = C1_CT;
    in_valid_a  = 1'b1;
    out_ready_a = 1'b1;
    for (int cyc = 0; cyc < 24; cyc++) begin
      if (cyc > 0) @(negedge clk);
      #1;
      chkb("b2b_in_ready", in_ready_a, (cyc == 0 || cyc == 12));
      chkb("b2b_out_valid", out_valid_a, (cyc == 11 || cyc == 23));
      if (cyc == 11 || cyc == 23) chk("b2b_pt", pt_a, PT);
      if (cyc == 23) in_valid_a = 1'b0;
    end
    @(negedge clk);
    #1;
    chkb("b2b_idle_ready", in_ready_a, 1'b1);
    chkb("b2b_idle_busy", busy_a, 1'b0);

    // Reset while ROUND with r=5.
    ct_a       = C1_CT;
    in_valid_a = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      in_valid_a = 1'b0;
      #1;
    end
    chk4("mid_rk_idx", rk_idx_a, 4'd5);
    rst_n = 1'b0;
    #1;
    chkb("mid_rst_valid", out_valid_a, 1'b0);
    chkb("mid_rst_busy", busy_a, 1'b0);
    chkb("mid_rst_ready", in_ready_a, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chkb("mid_rel_ready", in_ready_a, 1'b1);
    chkb("mid_rel_busy", busy_a, 1'b0);
    chk4("mid_rel_rk_idx", rk_idx_a, 4'd10);
    chk("mid_rel_pt", pt_a, 128'h0);
    ct_a       = C1_CT;
    in_valid_a = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      in_valid_a = 1'b0;
      #1;
      chkb("mid_new_valid", out_valid_a, (k == 11));
      if (k == 11) chk("mid_new_pt", pt_a, PT);
    end
    @(negedge clk);
    #1;
    chkb("mid_new_idle", busy_a, 1'b0);

    // AES-256 C.3.
    ct_b        = C3_CT;
    in_valid_b  = 1'b1;
    out_ready_b = 1'b1;
    chk4("c3_rk_idx_first", rk_idx_b, 4'd14);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      in_valid_b = 1'b0;
      #1;
      chkb("c3_out_valid", out_valid_b, (k == 15));
      if (k == 14) chk4("c3_rk_idx_last", rk_idx_b, 4'd0);
      if (k == 15) chk("c3_pt", pt_b, PT);
    end
    @(negedge clk);
    #1;
    chkb("c3_idle_ready", in_ready_b, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/aes_inv_cipher_ctrl.md
# aes_inv_cipher_ctrl

Iterative AES inverse-cipher engine: a round sequencer and state register that drive one shared InvShiftRows / InvSubBytes / AddRoundKey / inverseMixColumns round datapath, one round per clock. It accepts one 128-bit ciphertext block over a valid/ready handshake. Round keys come from an external key-expansion store, addressed by an index output and returned combinationally. The plaintext is returned over a second valid/ready handshake. It sits between the decrypt input buffer and the output formatter.

## Interface
- NR, default 10: number of rounds. Legal values are 10, 12, 14; any other value is a synthesis error.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  ciphertext valid.
- in_ready  out  1  engine can accept a block.
- ciphertext  in  128  input block; byte 0 (s0,0) is bits [127:120]; column c occupies [127-32c -: 32].
- rk_idx  out  4  round-key index requested this cycle.
- round_key  in  128  key for rk_idx, valid in the same cycle (combinational lookup), same byte order as ciphertext.
- out_valid  out  1  plaintext valid.
- out_ready  in  1  consumer accepts plaintext.
- plaintext  out  128  result block (state register).
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states are IDLE, ROUND, FINAL, DONE. Round counter r is 4 bits wide.
- IDLE:
  - in_ready=1, rk_idx=NR.
  - On in_valid&in_ready: state <= ciphertext ^ round_key, r <= NR-1, go to ROUND.
- ROUND:
  - rk_idx=r.
  - state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ round_key).
  - If r==1, go to FINAL; otherwise r <= r-1.
- FINAL:
  - rk_idx=0.
  - state <= InvSubBytes(InvShiftRows(state)) ^ round_key.
  - Go to DONE.
- DONE:
  - out_valid=1; plaintext holds.
  - On out_ready, go to IDLE.
- in_ready=0 in ROUND, FINAL and DONE. in_valid is ignored outside IDLE; the ciphertext is never sampled there.
- rk_idx depends only on FSM/counter registers, with no combinational path from any input.
- All GF(2^8) arithmetic uses reduction polynomial 0x11B. InvMixColumns uses matrix rows {0e,0b,0d,09} rotated per row, applied to each column.
- Reset (rst_n=0 at an edge), from any state including mid-round:
  - FSM -> IDLE; r <= NR-1; state/plaintext <= 0.
  - While rst_n is low, out_valid=0, busy=0, in_ready=0.
  - Any in-flight block is discarded with no output.
- Simultaneous events: in DONE with out_ready=1 and in_valid=1, the output is taken. The new block is not accepted until the following IDLE cycle.

## Timing
- Acceptance edge = cycle 0.
- ROUND occupies cycles 1..NR-1; FINAL is cycle NR; out_valid rises at cycle NR+1. Latency: AES-128 11, AES-192 13, AES-256 15.
- With out_ready held high, the earliest next acceptance is cycle NR+2. Sustained throughput is one block per NR+2 cycles.
- plaintext and out_valid are registered and stable while out_valid=1 && out_ready=0.
- Reset values:
  - out_valid=0, busy=0, plaintext=0, rk_idx=NR.
  - in_ready=1 from the first cycle with rst_n=1.

## Test plan
- AES-128 (FIPS-197 C.1), NR=10:
  - Stimulus: ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, round keys from a reference expansion of key 000102030405060708090a0b0c0d0e0f.
  - Required: plaintext 00112233445566778899aabbccddeeff with out_valid at cycle 11.
  - Required: rk_idx sequence 10,9,…,1,0 on cycles 0..10.
- AES-256 (FIPS-197 C.3), NR=14:
  - Stimulus: ciphertext 8ea2b7ca516745bfeafc49904b496089, key 000102…1f.
  - Required: plaintext 00112233445566778899aabbccddeeff at cycle 15.
- Backpressure:
  - Stimulus: out_ready=0 for 6 cycles after out_valid, with in_valid=1 and changing ciphertext.
  - Required: plaintext constant, in_ready=0, no block accepted; handshake completes on the cycle out_ready rises.
- Back-to-back:
  - Stimulus: two C.1 blocks with in_valid and out_ready held high.
  - Required: acceptances at cycles 0 and 12; both outputs correct.
- Reset mid-operation:
  - Stimulus: rst_n=0 for one cycle while in ROUND with r=5.
  - Required: out_valid never asserts for that block; in_ready=1 the next cycle; a fresh C.1 block then decrypts correctly with 11-cycle latency.
